// File: rtl/marcador_pkg.sv
// Shared constants and the BCD-to-7-segment decoder for the scoreboard display.
package marcador_pkg;

    // Active-low anode patterns, one per display digit
    localparam logic [3:0] AN_OFF   = 4'b1111;
    localparam logic [3:0] AN_O_UNI = 4'b1110;
    localparam logic [3:0] AN_O_DEC = 4'b1101;
    localparam logic [3:0] AN_X_UNI = 4'b1011;
    localparam logic [3:0] AN_X_DEC = 4'b0111;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decimal digit to active-low {g,f,e,d,c,b,a}; non-decimal codes are blanked
    function automatic logic [6:0] bcd_a_7seg(input logic [3:0] digito);
        logic [6:0] seg;
        case (digito)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/marcador_puntaje_contador_bcd.sv
// Two-digit BCD score counter that saturates at MAX_SCORE.
module contador_bcd #(
    parameter int unsigned MAX_SCORE = 99
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [7:0] bcd
);

    localparam logic [7:0] MAX_BCD = {4'(MAX_SCORE / 10), 4'(MAX_SCORE % 10)};

    logic [7:0] bcd_q;
    logic [7:0] bcd_d;

    // Next score: clear beats increment, increment holds at the ceiling
    always_comb begin
        bcd_d = bcd_q;
        if (clear) begin
            bcd_d = 8'h00;
        end else if (inc && (bcd_q != MAX_BCD)) begin
            if (bcd_q[3:0] == 4'd9) begin
                bcd_d = {bcd_q[7:4] + 4'd1, 4'd0};
            end else begin
                bcd_d = {bcd_q[7:4], bcd_q[3:0] + 4'd1};
            end
        end
    end

    // Score register
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            bcd_q <= 8'h00;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd = bcd_q;

endmodule

// File: rtl/marcador_puntaje.sv
// Scoreboard: synchronizes FSM score controls, keeps X/O BCD scores and
// drives the 4-digit multiplexed 7-segment display.
module marcador_puntaje
    import marcador_pkg::*;
#(
    parameter int unsigned REFRESH_BITS  = 17,
    parameter int unsigned MAX_SCORE     = 99,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       inc_x_score,
    input  logic       inc_o_score,
    input  logic       resetScore,
    output logic [7:0] score_x_bcd,
    output logic [7:0] score_o_bcd,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // Synchronizer chains; bit 0 = inc_x, bit 1 = inc_o, bit 2 = resetScore.
    // resetScore is used as a level, so it needs no third stage.
    logic [2:0] s1_q, s1_d, s2_q, s2_d;
    logic [1:0] s3_q, s3_d;

    logic inc_x_c, inc_o_c, clear_c;

    logic [REFRESH_BITS-1:0] refresco_q, refresco_d;
    logic [1:0]              sel;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              digito;
    logic                    es_decena;

    // Next values of the synchronizer / edge-history chain
    always_comb begin
        s1_d = {resetScore, inc_o_score, inc_x_score};
        s2_d = s1_q;
        s3_d = s2_q[1:0];
    end

    // Chain resets high so an input already high at release gives no pulse
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            s1_q <= 3'b111;
            s2_q <= 3'b111;
            s3_q <= 2'b11;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign inc_x_c = s2_q[0] & ~s3_q[0];
    assign inc_o_c = s2_q[1] & ~s3_q[1];
    assign clear_c = s2_q[2];

    contador_bcd #(.MAX_SCORE(MAX_SCORE)) u_contador_x (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (clear_c),
        .inc        (inc_x_c),
        .bcd        (score_x_bcd)
    );

    contador_bcd #(.MAX_SCORE(MAX_SCORE)) u_contador_o (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clear      (clear_c),
        .inc        (inc_o_c),
        .bcd        (score_o_bcd)
    );

    assign sel = refresco_q[REFRESH_BITS-1 -: 2];

    // Digit selection, decoding and leading-zero blanking
    always_comb begin
        refresco_d = refresco_q + REFRESH_BITS'(1);
        an_d       = AN_OFF;
        digito     = 4'd0;
        es_decena  = 1'b0;
        case (sel)
            2'd0: begin an_d = AN_O_UNI; digito = score_o_bcd[3:0]; end
            2'd1: begin an_d = AN_O_DEC; digito = score_o_bcd[7:4]; es_decena = 1'b1; end
            2'd2: begin an_d = AN_X_UNI; digito = score_x_bcd[3:0]; end
            default: begin an_d = AN_X_DEC; digito = score_x_bcd[7:4]; es_decena = 1'b1; end
        endcase
        if ((BLANK_LEADING != 0) && es_decena && (digito == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = bcd_a_7seg(digito);
        end
    end

    // Refresh counter and registered display outputs
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            refresco_q <= '0;
            an_q       <= AN_OFF;
            seg_q      <= SEG_BLANK;
        end else begin
            refresco_q <= refresco_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_marcador_puntaje.sv
// Scoreboard bench for marcador_puntaje: a history-based reference model
// pushes the expected outputs of every edge, a monitor pops and compares.
module tb_marcador_puntaje;

    localparam int RB   = 4;
    localparam int MAXS = 99;
    localparam int HN   = 20000;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic       inc_x_score = 1'b0;
    logic       inc_o_score = 1'b0;
    logic       resetScore = 1'b0;
    logic [7:0] score_x_bcd, score_o_bcd;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk_100MHz = ~clk_100MHz;

    marcador_puntaje #(.REFRESH_BITS(RB), .MAX_SCORE(MAXS), .BLANK_LEADING(1)) dut (
        .clk_100MHz  (clk_100MHz),
        .reset       (reset),
        .inc_x_score (inc_x_score),
        .inc_o_score (inc_o_score),
        .resetScore  (resetScore),
        .score_x_bcd (score_x_bcd),
        .score_o_bcd (score_o_bcd),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    typedef struct {
        int         cyc;
        logic [7:0] x;
        logic [7:0] o;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 3;
    bit   started = 0;
    bit   hx[HN];
    bit   ho[HN];
    bit   hr[HN];
    int   ex = 0, eo = 0, cnt = 0;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, req);
        end
    endtask

    // Reference model: inputs sampled at edge k take effect at edge k+2;
    // reset makes the input history look "already high".
    always @(posedge clk_100MHz) begin : model
        exp_t e;
        int   sel, d, ox, oo;
        cyc = cyc + 1;
        if (cyc < HN) begin
            hx[cyc] = inc_x_score;
            ho[cyc] = inc_o_score;
            hr[cyc] = resetScore;
            if (reset) begin
                started = 1;
                ex = 0; eo = 0; cnt = 0;
                for (int k = 0; k < 3; k++) begin
                    hx[cyc-k] = 1; ho[cyc-k] = 1; hr[cyc-k] = 1;
                end
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                ox = ex; oo = eo;
                sel = (cnt >> (RB - 2)) % 4;
                case (sel)
                    0: d = oo % 10;
                    1: d = oo / 10;
                    2: d = ox % 10;
                    default: d = ox / 10;
                endcase
                e.an  = 4'(~(32'd1 << sel));
                e.seg = ((sel % 2 == 1) && (d == 0)) ? 7'h7F : segtab[d];
                cnt = (cnt + 1) % (1 << RB);
                if (hr[cyc-2]) ex = 0;
                else if (hx[cyc-2] && !hx[cyc-3] && ex < MAXS) ex = ex + 1;
                if (hr[cyc-2]) eo = 0;
                else if (ho[cyc-2] && !ho[cyc-3] && eo < MAXS) eo = eo + 1;
            end
            e.cyc = cyc;
            e.x   = to_bcd(ex);
            e.o   = to_bcd(eo);
            if (started) sbq.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the expectation for this edge
    always @(negedge clk_100MHz) begin : monitor
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) void'(sbq.pop_front());
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            chk("score_x", 32'(score_x_bcd), 32'(e.x));
            chk("score_o", 32'(score_o_bcd), 32'(e.o));
            chk("an", 32'(an), 32'(e.an));
            chk("seg", 32'(seg), 32'(e.seg));
            chk("dp", 32'(dp), 32'd1);
        end
    end

    task automatic drive(input logic x, input logic o, input logic r, input logic rs, input int n);
        repeat (n) begin
            @(negedge clk_100MHz);
            inc_x_score = x;
            inc_o_score = o;
            resetScore  = r;
            reset       = rs;
        end
    endtask

    initial begin : stim
        bit found;
        drive(0, 0, 0, 1, 3);
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        drive(0, 0, 0, 0, 8 * (1 << RB));
        chk("idle_x", 32'(score_x_bcd), 32'h00);
        chk("idle_o", 32'(score_o_bcd), 32'h00);

        repeat (3) begin
            drive(1, 0, 0, 0, 20);
            drive(0, 0, 0, 0, 20);
        end
        chk("x_three", 32'(score_x_bcd), 32'h03);
        chk("o_zero", 32'(score_o_bcd), 32'h00);

        repeat (9) begin
            drive(0, 1, 0, 0, 6);
            drive(0, 0, 0, 0, 6);
        end
        chk("o_nine", 32'(score_o_bcd), 32'h09);
        drive(0, 1, 0, 0, 6);
        drive(0, 0, 0, 0, 6);
        chk("o_ten", 32'(score_o_bcd), 32'h10);
        found = 0;
        for (int i = 0; i < 4 * (1 << RB) && !found; i++) begin
            @(negedge clk_100MHz);
            if (an == 4'b1101) found = 1;
        end
        chk("o_tens_visit", 32'(found), 32'd1);
        if (found) chk("o_tens_seg", 32'(seg), 32'h79);

        repeat (105) begin
            drive(1, 0, 0, 0, 4);
            drive(0, 0, 0, 0, 4);
        end
        chk("x_sat", 32'(score_x_bcd), 32'h99);
        drive(0, 0, 0, 0, 50);
        chk("x_sat_hold", 32'(score_x_bcd), 32'h99);

        drive(0, 0, 1, 0, 6);
        drive(0, 0, 0, 0, 6);
        repeat (4) begin drive(1, 0, 0, 0, 5); drive(0, 0, 0, 0, 5); end
        repeat (7) begin drive(0, 1, 0, 0, 5); drive(0, 0, 0, 0, 5); end
        chk("x_four", 32'(score_x_bcd), 32'h04);
        chk("o_seven", 32'(score_o_bcd), 32'h07);
        drive(1, 1, 0, 0, 10);
        chk("x_both", 32'(score_x_bcd), 32'h05);
        chk("o_both", 32'(score_o_bcd), 32'h08);
        drive(0, 0, 0, 0, 6);
        drive(1, 0, 1, 0, 10);
        drive(1, 0, 0, 0, 20);
        chk("x_clr_wins", 32'(score_x_bcd), 32'h00);
        chk("o_clr_wins", 32'(score_o_bcd), 32'h00);
        drive(0, 0, 0, 0, 6);

        drive(0, 1, 0, 0, 10);
        drive(0, 1, 0, 1, 3);
        drive(0, 1, 0, 0, 20);
        chk("o_high_thru_rst", 32'(score_o_bcd), 32'h00);
        drive(0, 0, 0, 0, 6);
        drive(0, 1, 0, 0, 6);
        chk("o_after_rise", 32'(score_o_bcd), 32'h01);

        repeat (600) begin
            drive(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 10 == 0),
                  1'($urandom % 60 == 0), 1 + int'($urandom % 6));
        end
        drive(0, 0, 0, 0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
